// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared CPU constants for the P7 MIPS pipeline: reset PC, exception vector,
//   instruction-memory window and CP0 ExcCode values. CP0 and every pipeline
//   stage import this package, so they all use the same numbers.
//   Also defines the IF/ID payload struct and the fetch-address check.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_END   = 32'h0000_6FFC;

    // ExcCode values as written into CP0 Cause.ExcCode. Zero doubles as
    // "no exception" inside the pipeline, because interrupts are injected
    // by CP0 directly and never travel down the stage registers.
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } if_id_t;

    // Fetch address error: misaligned, or outside the IM window.
    // Compares are unsigned.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr > IM_END);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// fetch_stage_if_id_reg
//   IF/ID pipeline register with hold, bubble and load controls.
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset (clears everything)
//     i_hold    keep current contents (highest priority after reset)
//     i_bubble  load a bubble: pc <= i_pc, everything else cleared
//     i_pc, i_instr, i_exc, i_bd   payload for a normal load
//     o_pc, o_instr, o_exc, o_bd, o_valid   D-stage outputs
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hold,
    input  logic        i_bubble,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic [4:0]  i_exc,
    input  logic        i_bd,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic [4:0]  o_exc,
    output logic        o_bd,
    output logic        o_valid
);

    if_id_t r_if_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id <= '0;
        end else if (!i_hold) begin
            if (i_bubble) begin
                // Bubbles still carry a PC so EPC selection downstream never
                // sees an undefined value.
                r_if_id.pc    <= i_pc;
                r_if_id.instr <= 32'h0000_0000;
                r_if_id.exc   <= EXC_NONE;
                r_if_id.bd    <= 1'b0;
                r_if_id.valid <= 1'b0;
            end else begin
                r_if_id.pc    <= i_pc;
                r_if_id.instr <= i_instr;
                r_if_id.exc   <= i_exc;
                r_if_id.bd    <= i_bd;
                r_if_id.valid <= 1'b1;
            end
        end
    end

    assign o_pc    = r_if_id.pc;
    assign o_instr = r_if_id.instr;
    assign o_exc   = r_if_id.exc;
    assign o_bd    = r_if_id.bd;
    assign o_valid = r_if_id.valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   PC register plus IF/ID pipeline register of the P7 MIPS pipeline.
//   Ports:
//     clk       system clock, rising edge
//     reset     asynchronous active-low reset
//     npc       next PC from the NPC block
//     stall     hazard-unit stall of IF and ID
//     req       exception/interrupt taken this cycle (from CP0)
//     eret_d    ERET in D stage: squash the instruction behind it
//     branch_d  D instruction is a branch/jump; next fetch is a delay slot
//     instr_f   instruction read from IM at pc_f
//     pc_f      current fetch PC (to IM and NPC)
//     pc_d, instr_d, exc_d, bd_d, valid_d   D-stage outputs
//   Edge priority: req > stall > eret_d > normal fetch.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        req,
    input  logic        eret_d,
    input  logic        branch_d,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic [4:0]  exc_d,
    output logic        bd_d,
    output logic        valid_d
);

    logic [31:0] r_pc_f;
    logic        w_adel;
    logic        w_hold;
    logic        w_bubble;
    logic [31:0] w_pc_load;
    logic [31:0] w_instr_load;
    logic [4:0]  w_exc_load;

    // The PC itself is never masked; a bad address still goes to IM and
    // only the IF/ID payload is suppressed.
    assign w_adel = fetch_addr_bad(r_pc_f);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_f <= RESET_PC;
        end else if (req) begin
            r_pc_f <= EXC_VEC;
        end else if (!stall) begin
            // ERET and normal fetch both follow npc: NPC already supplies EPC.
            r_pc_f <= npc;
        end
    end

    assign pc_f = r_pc_f;

    // req overrides stall; both req and eret_d load a bubble, but an
    // exception bubble is tagged with the handler address.
    assign w_hold       = stall & ~req;
    assign w_bubble     = req | eret_d;
    assign w_pc_load    = req ? EXC_VEC : r_pc_f;
    assign w_instr_load = w_adel ? 32'h0000_0000 : instr_f;
    assign w_exc_load   = w_adel ? EXC_ADEL : EXC_NONE;

    fetch_stage_if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (reset),
        .i_hold   (w_hold),
        .i_bubble (w_bubble),
        .i_pc     (w_pc_load),
        .i_instr  (w_instr_load),
        .i_exc    (w_exc_load),
        .i_bd     (branch_d),
        .o_pc     (pc_d),
        .o_instr  (instr_d),
        .o_exc    (exc_d),
        .o_bd     (bd_d),
        .o_valid  (valid_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        req;
    logic        eret_d;
    logic        branch_d;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [4:0]  exc_d;
    logic        bd_d;
    logic        valid_d;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] pcd;
        logic [31:0] ins;
        logic [4:0]  exc;
        logic        bd;
        logic        v;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [31:0] I0 = 32'h3C01_1234;
    localparam logic [31:0] I1 = 32'hDEAD_BEEF;
    localparam logic [31:0] I2 = 32'h2001_0005;
    localparam logic [31:0] I3 = 32'h0000_0020;
    localparam logic [31:0] I4 = 32'h1000_0003;
    localparam logic [31:0] I5 = 32'h2402_0001;

    fetch_stage dut (
        .clk      (clk),
        .reset    (reset),
        .npc      (npc),
        .stall    (stall),
        .req      (req),
        .eret_d   (eret_d),
        .branch_d (branch_d),
        .instr_f  (instr_f),
        .pc_f     (pc_f),
        .pc_d     (pc_d),
        .instr_d  (instr_d),
        .exc_d    (exc_d),
        .bd_d     (bd_d),
        .valid_d  (valid_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_tests++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req_v);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " pc_f"},    pc_f,    e.pcf);
        chk({tag, " pc_d"},    pc_d,    e.pcd);
        chk({tag, " instr_d"}, instr_d, e.ins);
        chk({tag, " exc_d"},   {27'd0, exc_d},   {27'd0, e.exc});
        chk({tag, " bd_d"},    {31'd0, bd_d},    {31'd0, e.bd});
        chk({tag, " valid_d"}, {31'd0, valid_d}, {31'd0, e.v});
        $display("[TB] %s pc_f=%h pc_d=%h instr_d=%h exc_d=%0d bd_d=%0d valid_d=%0d",
                 tag, pc_f, pc_d, instr_d, exc_d, bd_d, valid_d);
    endtask

    // Monitor: one expectation is consumed per clock edge, sampled 1 time
    // unit after the edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_txn++;
            chk_all($sformatf("txn%0d", n_txn), e);
        end
    end

    // Drive one cycle's inputs (at a negedge) and queue the state expected
    // right after the following rising edge.
    task automatic cyc(input logic [31:0] i_npc, input logic i_stall, input logic i_req,
                       input logic i_eret, input logic i_br, input logic [31:0] i_instr,
                       input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                       input logic [31:0] e_ins, input logic [4:0] e_exc,
                       input logic e_bd, input logic e_v);
        exp_t e;
        npc      = i_npc;
        stall    = i_stall;
        req      = i_req;
        eret_d   = i_eret;
        branch_d = i_br;
        instr_f  = i_instr;
        e.pcf = e_pcf; e.pcd = e_pcd; e.ins = e_ins;
        e.exc = e_exc; e.bd = e_bd;  e.v = e_v;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t r;
        reset = 1'b1; npc = 32'h0; stall = 1'b0; req = 1'b0;
        eret_d = 1'b0; branch_d = 1'b0; instr_f = 32'h0;
        #2 reset = 1'b0;
        #1;
        // Reset state, before any clock edge.
        r.pcf = 32'h3000; r.pcd = 32'h0; r.ins = 32'h0; r.exc = 5'd0; r.bd = 1'b0; r.v = 1'b0;
        chk_all("reset", r);

        @(negedge clk);
        reset = 1'b1;
        //   npc       stl req ert br  instr    pc_f      pc_d      instr_d  exc bd v
        cyc(32'h3004, 0, 0, 0, 0, I0, 32'h3004, 32'h3000, I0, 5'd0, 0, 1);
        cyc(32'h3008, 0, 0, 0, 0, I0, 32'h3008, 32'h3004, I0, 5'd0, 0, 1);
        // Two-cycle stall at 0x3008: everything holds.
        cyc(32'h300C, 1, 0, 0, 0, I1, 32'h3008, 32'h3004, I0, 5'd0, 0, 1);
        cyc(32'h300C, 1, 0, 0, 0, I1, 32'h3008, 32'h3004, I0, 5'd0, 0, 1);
        cyc(32'h300C, 0, 0, 0, 0, I2, 32'h300C, 32'h3008, I2, 5'd0, 0, 1);
        cyc(32'h3010, 0, 0, 0, 0, I3, 32'h3010, 32'h300C, I3, 5'd0, 0, 1);
        // Branch in D while fetching 0x3010 -> delay-slot flag.
        cyc(32'h3014, 0, 0, 0, 1, I4, 32'h3014, 32'h3010, I4, 5'd0, 1, 1);
        cyc(32'h3018, 0, 0, 0, 0, I5, 32'h3018, 32'h3014, I5, 5'd0, 0, 1);
        // stall and req together: req wins.
        cyc(32'h3020, 1, 1, 0, 0, I0, 32'h4180, 32'h4180, 32'h0, 5'd0, 0, 0);
        // Misaligned and out-of-range fetches, plus window boundaries.
        cyc(32'h3002, 0, 0, 0, 0, I0, 32'h3002, 32'h4180, I0, 5'd0, 0, 1);
        cyc(32'h7000, 0, 0, 0, 0, I0, 32'h7000, 32'h3002, 32'h0, 5'd4, 0, 1);
        cyc(32'h6FFC, 0, 0, 0, 0, I0, 32'h6FFC, 32'h7000, 32'h0, 5'd4, 0, 1);
        cyc(32'h2FFC, 0, 0, 0, 0, I0, 32'h2FFC, 32'h6FFC, I0, 5'd0, 0, 1);
        cyc(32'h3000, 0, 0, 0, 0, I0, 32'h3000, 32'h2FFC, 32'h0, 5'd4, 0, 1);
        cyc(32'h3004, 0, 0, 0, 0, I0, 32'h3004, 32'h3000, I0, 5'd0, 0, 1);
        // ERET in D: follow npc, squash the fetched instruction.
        cyc(32'h3020, 0, 0, 1, 0, I2, 32'h3020, 32'h3004, 32'h0, 5'd0, 0, 0);
        cyc(32'h3024, 0, 0, 0, 0, I3, 32'h3024, 32'h3020, I3, 5'd0, 0, 1);
        // stall outranks eret_d.
        cyc(32'h3040, 1, 0, 1, 0, I4, 32'h3024, 32'h3020, I3, 5'd0, 0, 1);
        cyc(32'h3028, 0, 0, 0, 1, I4, 32'h3028, 32'h3024, I4, 5'd0, 1, 1);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        r.pcf = 32'h3000; r.pcd = 32'h0; r.ins = 32'h0; r.exc = 5'd0; r.bd = 1'b0; r.v = 1'b0;
        chk_all("async_reset", r);
        // req/stall while reset is held are ignored.
        req = 1'b1; stall = 1'b1;
        @(posedge clk);
        #1;
        chk_all("reset_held", r);
        @(negedge clk);
        reset = 1'b1;
        cyc(32'h3004, 0, 0, 0, 0, I0, 32'h3004, 32'h3000, I0, 5'd0, 0, 1);

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
